// File: rtl/pool_ctrl.sv
// Frame sequencer for the 2x2 max-pooling engine: clears the engine, streams
// conv words into it, runs the pooling pass and forwards results to the buffer.
module pool_ctrl #(
  parameter int N          = 3,
  parameter int LOAD_BEATS = 4*N*N,
  parameter int TIMEOUT    = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        in_valid,
  input  logic [15:0] in_data,
  output logic        in_ready,
  output logic        pe_rst_n,
  output logic        pe_en_reg,
  output logic        pe_en_pool,
  output logic [15:0] pe_data,
  input  logic [15:0] pe_pool_out,
  input  logic [15:0] pe_addr,
  input  logic        pe_done,
  output logic        out_wr_en,
  output logic [15:0] out_addr,
  output logic [15:0] out_data,
  output logic        busy,
  output logic        frame_done,
  output logic        err
);
  localparam logic [7:0] BEATS_LAST = 8'(LOAD_BEATS);
  localparam logic [8:0] RESULTS    = 9'(N*N);
  localparam logic [7:0] WD_LIMIT   = 8'(TIMEOUT);

  typedef enum logic [2:0] {IDLE, CLEAR, LOAD, POOL, FIN} state_e;

  state_e      state_q, state_d;
  logic [7:0]  beat_q, beat_d;
  logic [7:0]  wr_q, wr_d;
  logic [7:0]  wd_q, wd_d;
  logic        err_q, err_d;
  logic [15:0] last_addr_q, last_addr_d;
  logic        wr_en_q, wr_en_d;
  logic [15:0] out_addr_q, out_addr_d;
  logic [15:0] out_data_q, out_data_d;
  logic        clr_n_q;
  logic        wr_now;
  logic [8:0]  wr_total;

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    wr_d        = wr_q;
    wd_d        = wd_q;
    err_d       = err_q;
    last_addr_d = last_addr_q;
    wr_en_d     = 1'b0;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    wr_now      = 1'b0;
    wr_total    = {1'b0, wr_q};
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          err_d   = 1'b0;
          beat_d  = 8'd0;
          wr_d    = 8'd0;
          wd_d    = 8'd0;
        end
      end
      CLEAR: state_d = LOAD;
      LOAD: begin
        if (in_valid) begin
          beat_d = beat_q + 8'd1;
          if (beat_d == BEATS_LAST) state_d = POOL;
        end
      end
      POOL: begin
        // wr_q==0 marks the first POOL cycle, which always writes
        wr_now   = ({1'b0, wr_q} < RESULTS) && ((wr_q == 8'd0) || (pe_addr != last_addr_q));
        wr_total = {1'b0, wr_q} + {8'd0, wr_now};
        wd_d     = wd_q + 8'd1;
        if (wr_now) begin
          wr_d        = wr_total[7:0];
          wr_en_d     = 1'b1;
          out_addr_d  = pe_addr;
          out_data_d  = pe_pool_out;
          last_addr_d = pe_addr;
        end
        if (pe_done) begin
          state_d = FIN;
          if (wr_total != RESULTS) err_d = 1'b1;
        end else if (wd_d == WD_LIMIT) begin
          state_d = FIN;
          err_d   = 1'b1;
        end
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // clr_n_q resets high so pe_rst_n tracks reset_n exactly while reset is held
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      beat_q      <= 8'd0;
      wr_q        <= 8'd0;
      wd_q        <= 8'd0;
      err_q       <= 1'b0;
      last_addr_q <= 16'd0;
      wr_en_q     <= 1'b0;
      out_addr_q  <= 16'd0;
      out_data_q  <= 16'd0;
      clr_n_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      wr_q        <= wr_d;
      wd_q        <= wd_d;
      err_q       <= err_d;
      last_addr_q <= last_addr_d;
      wr_en_q     <= wr_en_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
      clr_n_q     <= (state_d != CLEAR);
    end
  end

  assign in_ready   = (state_q == LOAD);
  assign pe_en_reg  = in_ready & in_valid;
  assign pe_data    = in_ready ? in_data : 16'd0;
  assign pe_en_pool = (state_q == POOL);
  assign pe_rst_n   = reset_n & clr_n_q;
  assign out_wr_en  = wr_en_q;
  assign out_addr   = out_addr_q;
  assign out_data   = out_data_q;
  assign busy       = (state_q != IDLE);
  assign frame_done = (state_q == FIN);
  assign err        = err_q;

endmodule

// File: doc/pool_ctrl.md
# pool_ctrl

Frame sequencer for the 2x2 max-pooling engine (POOLING) in the CNN datapath. Per frame: clears the engine, streams LOAD_BEATS convolution words into it, runs the pooling pass, and forwards the N*N pooled results to a result buffer write port. Sits between the conv output stream and the pooling engine; the top-level scheduler drives it through a start/busy/frame_done handshake.

## Interface
Parameters:
- N, 3, pooled output side; engine input is 2N x 2N, result count N*N
- LOAD_BEATS, 4*N*N, accepted input words per frame (range 1..255)
- TIMEOUT, 64, maximum POOL-state cycles before error (range 2..255)

Ports:
- clk  in  1  single clock, rising edge
- reset_n  in  1  asynchronous, active-low reset
- start  in  1  frame request, sampled only in IDLE
- in_valid  in  1  conv word valid
- in_data  in  16  conv word
- in_ready  out  1  controller accepts in_data this cycle
- pe_rst_n  out  1  engine reset, active-low
- pe_en_reg  out  1  engine load enable
- pe_en_pool  out  1  engine pooling enable
- pe_data  out  16  engine input word
- pe_pool_out  in  16  engine pooled value
- pe_addr  in  16  engine result address
- pe_done  in  1  engine pooling complete
- out_wr_en  out  1  result buffer write strobe
- out_addr  out  16  result buffer address
- out_data  out  16  result buffer data
- busy  out  1  frame in progress
- frame_done  out  1  one-cycle end-of-frame pulse
- err  out  1  sticky protocol/timeout error

## Operation
- States: IDLE, CLEAR, LOAD, POOL, FIN. Reset -> IDLE.
- IDLE: start=1 -> CLEAR; clears err, beat_cnt, wr_cnt, wd_cnt. start ignored in all other states.
- CLEAR: exactly one cycle; pe_rst_n=0 (registered, glitch-free) -> LOAD.
- LOAD: in_ready=1; pe_en_reg = in_valid; pe_data = in_data (combinational pass-through, 0 outside LOAD). beat_cnt increments per accepted word; accepting beat LOAD_BEATS -> POOL. in_valid gaps stall without penalty.
- POOL: pe_en_pool=1. Write issued on first POOL cycle and on any cycle where pe_addr differs from last written address, while wr_cnt < N*N; each write increments wr_cnt. out_addr=pe_addr, out_data=pe_pool_out.
- POOL exit: pe_done=1 with wr_cnt==N*N (counting any write issued that same cycle) -> FIN. pe_done=1 with fewer writes -> err=1, FIN. wd_cnt reaching TIMEOUT -> err=1, FIN.
- FIN: frame_done=1 for one cycle -> IDLE.
- busy=1 in CLEAR, LOAD, POOL, FIN.
- pe_rst_n = reset_n AND NOT(state==CLEAR); engine is held in reset while reset_n low.
- Counters saturate-free: beat_cnt 8 bit, wr_cnt 8 bit, wd_cnt 8 bit.

## Timing
- Reset values: in_ready 0, pe_rst_n 0 (follows reset_n), pe_en_reg 0, pe_en_pool 0, pe_data 0, out_wr_en 0, out_addr 0, out_data 0, busy 0, frame_done 0, err 0.
- start in cycle t -> CLEAR t+1 -> LOAD from t+2; busy high from t+1.
- in_ready, pe_en_reg, pe_data: combinational from state/in_*, zero latency.
- Write port registered: pe_addr/pe_pool_out sampled cycle k -> out_wr_en/out_addr/out_data valid cycle k+1, out_wr_en single-cycle per write.
- FIN entered the cycle after exit condition; final write (if any) and FIN coincide; frame_done same cycle busy drops to 0 next cycle.
- reset_n low mid-frame: immediate return to IDLE, all outputs to reset values, no frame_done.
- start held high through FIN: new frame begins in IDLE the following cycle (back-to-back frames, one IDLE cycle gap).

## Test plan
- Reset: reset_n=0 for 3 cycles -> all outputs at reset values, pe_rst_n=0; release -> state IDLE, busy=0.
- Nominal frame N=3: start, 36 words 0x0001..0x0024 continuous -> pe_rst_n low exactly 1 cycle, 36 pe_en_reg pulses, 9 writes addr 0..8 with engine max values, frame_done once, err=0.
- Stalled input: in_valid toggled 1/0 every cycle -> in_ready stays 1, exactly 36 pe_en_reg pulses, LOAD lasts 71 cycles.
- Timeout: engine model never asserts pe_done -> after 64 POOL cycles err=1, frame_done pulse, next start clears err.
- Early done: pe_done after 4 writes -> err=1, FIN, no further writes.
- Reset mid-LOAD at beat 20 -> outputs reset asynchronously, no frame_done; next start runs full clean frame.
